accel: RTL and testbench
========================

# accel

Multi-cycle arithmetic accelerator computing y = 3·a + 2·⌊∛b⌋ for 8-bit unsigned operands. It sits on the datapath as a start/busy slave: the host applies operands with a one-cycle start pulse, waits for busy to fall, then reads the held 16-bit result. The cube root uses a bitwise restoring algorithm built around one shared sequential 8×8 shift-add multiplier.

## Interface
- Parameters: none.
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled on a rising edge only while busy_out=0.
- a_in  input  8  operand a, unsigned; captured on accepted start.
- b_in  input  8  operand b, unsigned; captured on accepted start.
- busy_out  output  1  high while a computation is in progress.
- y_out  output  16  result, unsigned; held stable between completions.

## Operation
- Registers: a_r[7:0], x_r[7:0] (cube-root remainder, loaded with b), root_r[7:0], s_r (shift amount, values 6/3/0), state, multiplier internals.
- Cube root, three iterations for s = 6, 3, 0:
  - root ← 2·root;
  - t ← root·(root+1) from the shared multiplier;
  - cand ← (3·t + 1) << s, with 3·t = (t<<1)+t; evaluate in at least 16 bits, no truncation;
  - if x ≥ cand: x ← x − cand, root ← root + 1.
- Final root = ⌊∛b⌋, range 0..6.
- Result: y = (a<<1) + a + (root<<1), zero-extended to 16 bits. Maximum 777 (a=255, b=255), so no overflow.
- Multiplier: 8×8 unsigned shift-add, one partial product per cycle, exactly 8 cycles from launch to product valid; 16-bit product.
- FSM states:
  - IDLE: busy=0. On start_i=1, capture a_in/b_in, set root=0 and s=6, go ROOT_SHIFT.
  - ROOT_SHIFT (1 cycle): double root, launch multiply root·(root+1), go ROOT_MUL.
  - ROOT_MUL (8 cycles): wait for the product.
  - ROOT_CMP (1 cycle): compare and subtract as above. If s=0 go SUM, else s ← s−3 and go ROOT_SHIFT.
  - SUM (1 cycle): write y_out, go IDLE.
- start_i while busy=1 is ignored; no queuing.
- Operands are not re-sampled during a computation, so a_in/b_in may change freely after acceptance.
- y_out changes only in SUM and on reset.

## Timing
- Reset (rst_i=0, asynchronous): state=IDLE, busy_out=0, y_out=0, all internal registers 0.
- Reset asserted mid-operation aborts the computation; y_out=0 after reset, and no partial result is ever written.
- Edge E0 samples start_i=1 with busy=0: busy_out goes 1 after E0.
- Busy duration: 3×(1+8+1) + 1 = 31 cycles for all operands.
  - y_out is updated at edge E31 (the SUM edge).
  - busy_out falls at that same edge, so the new y_out is valid when busy_out is first seen low.
- A start pulse of exactly one cycle is sufficient. Holding start_i high causes back-to-back operations: a new capture occurs on the first edge after busy falls.
- Latency is data-independent, including b=0 and b=255.

## Test plan
- Reset then idle: rst_i low → busy_out=0, y_out=0. Release reset with start_i=0 → outputs unchanged.
- Perfect-cube sweep a=0..14, b=j³ for j=0..4 (1-cycle start, wait for busy to fall) → y=3a+2j. Check a=14, b=64 → 50, and a=5, b=125 → 25.
- Non-cubes: b=7 → root 1, a=0 → 2. b=255 with a=255 → 777. b=215 with a=0 → 10 (root 5). b=216 with a=0 → 12.
- Latency: count cycles from the start edge to busy fall → exactly 31 for every operand pair above.
- Start during busy: pulse start_i with new operands at cycle 10 of a run → ignored; result matches the original operands; busy length unchanged.
- Reset mid-operation: assert rst_i low at cycle 15 → busy_out=0 and y_out=0 immediately. A fresh start after release computes correctly.

Source files
------------

// File: rtl/accel.sv
// accel: y = 3a + 2*floor(cbrt(b)) via restoring cube root on a shared shift-add multiplier.
module accel (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [7:0]  a_in,
   input  logic [7:0]  b_in,
   output logic        busy_out,
   output logic [15:0] y_out
);
   typedef enum logic [2:0] {IDLE, ROOT_SHIFT, ROOT_MUL, ROOT_CMP, SUM} state_t;
   state_t      state;
   logic [7:0]  a_r, x_r, root_r, mp_r;
   logic [2:0]  s_r, cnt_r;
   logic [15:0] mc_r, acc_r;
   logic [7:0]  r2;
   logic [23:0] cand;
   assign r2   = {root_r[6:0], 1'b0};
   // 24 bits so (3t+1)<<6 never truncates
   assign cand = (({8'd0, acc_r} << 1) + {8'd0, acc_r} + 24'd1) << s_r;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         busy_out <= 1'b0;
         y_out    <= 16'd0;
         a_r      <= 8'd0;
         x_r      <= 8'd0;
         root_r   <= 8'd0;
         mp_r     <= 8'd0;
         s_r      <= 3'd0;
         cnt_r    <= 3'd0;
         mc_r     <= 16'd0;
         acc_r    <= 16'd0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               a_r      <= a_in;
               x_r      <= b_in;
               root_r   <= 8'd0;
               s_r      <= 3'd6;
               busy_out <= 1'b1;
               state    <= ROOT_SHIFT;
            end
            ROOT_SHIFT: begin
               root_r <= r2;
               mc_r   <= {8'd0, r2};
               mp_r   <= r2 + 8'd1;
               acc_r  <= 16'd0;
               cnt_r  <= 3'd0;
               state  <= ROOT_MUL;
            end
            ROOT_MUL: begin
               if (mp_r[0]) acc_r <= acc_r + mc_r;
               mc_r  <= mc_r << 1;
               mp_r  <= mp_r >> 1;
               cnt_r <= cnt_r + 3'd1;
               if (cnt_r == 3'd7) state <= ROOT_CMP;
            end
            ROOT_CMP: begin
               if ({16'd0, x_r} >= cand) begin
                  x_r    <= x_r - cand[7:0];
                  root_r <= root_r + 8'd1;
               end
               if (s_r == 3'd0) state <= SUM;
               else begin
                  s_r   <= s_r - 3'd3;
                  state <= ROOT_SHIFT;
               end
            end
            SUM: begin
               y_out    <= {7'd0, a_r, 1'b0} + {8'd0, a_r} + {7'd0, root_r, 1'b0};
               busy_out <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_accel.sv
// tb_accel: scoreboard bench for accel against an integer cube-root reference model.
module tb_accel;
   logic        clk_i = 0, rst_i = 0, start_i = 0, busy_out;
   logic [7:0]  a_in = 0, b_in = 0;
   logic [15:0] y_out;
   int          nvec = 0, nerr = 0;
   int          sb[$];
   int          cnt = 0;
   logic        prev = 0;

   accel dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .a_in(a_in), .b_in(b_in),
              .busy_out(busy_out), .y_out(y_out));

   always #5 clk_i = ~clk_i;

   function automatic int model(int a, int b);
      int r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
      return 3 * a + 2 * r;
   endfunction

   task automatic chk(string name, int act, int exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (!rst_i) begin
         prev = 0;
         cnt  = 0;
      end else begin
         if (busy_out) cnt++;
         else if (prev) begin
            if (sb.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_result: got y=%0d expected no completion", y_out);
            end else begin
               chk("y", int'(y_out), sb.pop_front());
               chk("latency", cnt, 31);
            end
            cnt = 0;
         end
         prev = busy_out;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy_out && n < 60) begin
         @(negedge clk_i);
         n++;
      end
      if (busy_out) begin
         nvec++;
         nerr++;
         $display("FAIL busy_timeout: got busy=1 expected 0 within 60 cycles");
      end
   endtask

   task automatic issue(int a, int b);
      @(negedge clk_i);
      a_in    = 8'(a);
      b_in    = 8'(b);
      start_i = 1;
      sb.push_back(model(a, b));
      @(negedge clk_i);
      start_i = 0;
      a_in    = 8'($urandom);
      b_in    = 8'($urandom);
   endtask

   task automatic run(int a, int b);
      issue(a, b);
      wait_idle();
   endtask

   initial begin
      repeat (2) @(negedge clk_i);
      chk("rst_busy", int'(busy_out), 0);
      chk("rst_y", int'(y_out), 0);
      #2 rst_i = 1;
      repeat (3) @(negedge clk_i);
      chk("idle_busy", int'(busy_out), 0);
      chk("idle_y", int'(y_out), 0);

      for (int a = 0; a <= 14; a++)
         for (int j = 0; j <= 4; j++) run(a, j * j * j);
      run(14, 64);
      run(5, 125);
      run(0, 7);
      run(255, 255);
      run(0, 215);
      run(0, 216);
      run(0, 0);
      for (int i = 0; i < 20; i++) run(int'($urandom_range(255)), int'($urandom_range(255)));

      // start pulse with other operands while busy must be ignored
      issue(200, 100);
      repeat (8) @(negedge clk_i);
      a_in    = 8'd17;
      b_in    = 8'd250;
      start_i = 1;
      @(negedge clk_i);
      start_i = 0;
      wait_idle();

      // held start gives back-to-back runs
      @(negedge clk_i);
      a_in    = 8'd33;
      b_in    = 8'd30;
      start_i = 1;
      sb.push_back(model(33, 30));
      @(negedge clk_i);
      wait_idle();
      a_in = 8'd77;
      b_in = 8'd200;
      sb.push_back(model(77, 200));
      @(negedge clk_i);
      start_i = 0;
      wait_idle();

      // reset mid-operation aborts and clears the result
      run(100, 9);
      issue(120, 150);
      repeat (13) @(negedge clk_i);
      #2 rst_i = 0;
      #1;
      chk("abort_busy", int'(busy_out), 0);
      chk("abort_y", int'(y_out), 0);
      sb.delete();
      repeat (2) @(negedge clk_i);
      #2 rst_i = 1;
      repeat (2) @(negedge clk_i);
      chk("post_abort_y", int'(y_out), 0);
      run(9, 27);

      repeat (3) @(negedge clk_i);
      chk("sb_drain", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
